// File: rtl/event_fifo_ts_if.sv
// AXI4-Lite bundle (32-bit address and data) shared by the event FIFO and its bus master.
interface axi4_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/event_fifo_ts.sv
// Timestamped event FIFO: captures {timestamp, code} on wr_en and is drained, configured and
// monitored through an AXI4-Lite slave (DATA register pops on read).
module event_fifo_ts #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned TS_W   = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              irq,
  axi4_lite_if.slave        axi
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = TS_W + DATA_W;

  localparam logic [31:0] AddrStatus  = 32'h00;
  localparam logic [31:0] AddrLevel   = 32'h04;
  localparam logic [31:0] AddrThresh  = 32'h08;
  localparam logic [31:0] AddrCtrl    = 32'h0C;
  localparam logic [31:0] AddrDropped = 32'h10;
  localparam logic [31:0] AddrData    = 32'h14;
  localparam logic [31:0] AddrTs      = 32'h18;
  localparam logic [1:0]  RespOkay    = 2'b00;
  localparam logic [1:0]  RespSlvErr  = 2'b10;

  typedef logic [AW-1:0]   ptr_t;
  typedef logic [AW:0]     lvl_t;
  typedef logic [TS_W-1:0] ts_t;

  logic [EW-1:0] mem [DEPTH];

  ts_t         ts_q, ts_d, last_ts_q, last_ts_d;
  ptr_t        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  lvl_t        level_q, level_d, thresh_q, thresh_d;
  logic [31:0] dropped_q, dropped_d, rdata_q, rdata_d, rd_mux_data;
  logic        ovf_q, ovf_d, en_q, en_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d, awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  rresp_q, rresp_d, bresp_q, bresp_d, rd_mux_resp;

  logic full, empty, at_thresh, ar_hs, wr_hs, wr_ctrl, flush, push, pop, drop;
  logic [EW-1:0] head;
  logic unused_bits;

  assign full      = (level_q == lvl_t'(DEPTH));
  assign empty     = (level_q == '0);
  assign at_thresh = (level_q >= thresh_q);
  assign ar_hs     = axi.arvalid && arready_q;
  assign wr_hs     = awready_q && axi.awvalid && axi.wvalid;
  assign wr_ctrl   = wr_hs && (axi.awaddr == AddrCtrl);
  assign flush     = wr_ctrl && axi.wdata[2];
  assign head      = mem[rd_ptr_q];
  assign pop       = ar_hs && (axi.araddr == AddrData) && !empty;
  // Full is judged on the pre-pop level, so a pop never makes room for a same-cycle write.
  assign push      = wr_en && en_q && !full && !flush;
  assign drop      = wr_en && en_q && full && !flush;

  assign unused_bits = ^{axi.wstrb, axi.wdata};

  always_comb begin
    rd_mux_data = '0;
    rd_mux_resp = RespOkay;
    case (axi.araddr)
      AddrStatus:  rd_mux_data[3:0] = {ovf_q, at_thresh, full, empty};
      AddrLevel:   rd_mux_data[AW:0] = level_q;
      AddrThresh:  rd_mux_data[AW:0] = thresh_q;
      AddrCtrl:    rd_mux_data[1:0] = {irq_en_q, en_q};
      AddrDropped: rd_mux_data = dropped_q;
      AddrData:    if (!empty) rd_mux_data[DATA_W-1:0] = head[DATA_W-1:0];
      AddrTs:      rd_mux_data[TS_W-1:0] = last_ts_q;
      default:     rd_mux_resp = RespSlvErr;
    endcase
  end

  always_comb begin
    ts_d      = ts_q + ts_t'(1);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    dropped_d = dropped_q;
    ovf_d     = ovf_q;
    thresh_d  = thresh_q;
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    last_ts_d = last_ts_q;
    level_d   = level_q + lvl_t'(push) - lvl_t'(pop);
    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + ptr_t'(1);
      last_ts_d = head[EW-1:DATA_W];
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (dropped_q != '1) dropped_d = dropped_q + 32'd1;
    end
    if (wr_hs && (axi.awaddr == AddrThresh)) thresh_d = axi.wdata[AW:0];
    if (wr_ctrl) begin
      en_d     = axi.wdata[0];
      irq_en_d = axi.wdata[1];
    end
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      dropped_d = '0;
      ovf_d     = 1'b0;
    end
    irq_d = irq_en_q && at_thresh;

    // Read channel: one outstanding transaction, arready low until R completes.
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_hs) begin
      arready_d = 1'b0;
      rvalid_d  = 1'b1;
      rdata_d   = rd_mux_data;
      rresp_d   = rd_mux_resp;
    end else begin
      if (rvalid_q && axi.rready) rvalid_d = 1'b0;
      if (!rvalid_q || axi.rready) arready_d = 1'b1;
    end

    // Write channel: single-cycle ready pulse once address and data are both present.
    awready_d = axi.awvalid && axi.wvalid && !bvalid_q && !awready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = ((axi.awaddr == AddrThresh) || (axi.awaddr == AddrCtrl)) ? RespOkay : RespSlvErr;
    end else if (axi.bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr_q] <= {ts_q, data_in};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      dropped_q <= '0;
      ovf_q     <= 1'b0;
      thresh_q  <= lvl_t'(DEPTH / 2);
      en_q      <= 1'b1;
      irq_en_q  <= 1'b0;
      last_ts_q <= '0;
      irq_q     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      ts_q      <= ts_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      dropped_q <= dropped_d;
      ovf_q     <= ovf_d;
      thresh_q  <= thresh_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      last_ts_q <= last_ts_d;
      irq_q     <= irq_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign irq         = irq_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.awready = awready_q;
  assign axi.wready  = awready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;

endmodule

// File: tb/tb_event_fifo_ts.sv
// Bench for event_fifo_ts: directed scenarios plus random push/pop traffic checked against a
// queue-based model of the FIFO, its counters and its register map.
module tb_event_fifo_ts;
  localparam int DATA_W = 9;
  localparam int DEPTH  = 512;
  localparam int TS_W   = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              irq;

  axi4_lite_if axi();

  event_fifo_ts #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .wr_en   (wr_en),
    .data_in (data_in),
    .irq     (irq),
    .axi     (axi)
  );

  always #5 clk = ~clk;

  // Reference free-running counter: value seen at a negedge is the next edge's timestamp.
  logic [31:0] cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 32'd1;
  end

  typedef struct packed {
    logic [31:0]       ts;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_dropped, m_thresh;
  bit          m_ovf, m_en, m_irqen;
  logic [31:0] m_last_ts;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd, pts, exp;
  logic [1:0]  rs;

  task automatic model_reset();
    mq.delete();
    m_dropped = 0; m_ovf = 0; m_en = 1; m_irqen = 0; m_thresh = DEPTH / 2; m_last_ts = '0;
  endtask

  function automatic logic [31:0] m_status();
    return {28'd0, m_ovf, mq.size() >= m_thresh, mq.size() == DEPTH, mq.size() == 0};
  endfunction

  task automatic m_push(input logic [DATA_W-1:0] d, input logic [31:0] ts);
    if (!m_en) return;
    if (mq.size() == DEPTH) begin
      if (m_dropped != 32'hFFFF_FFFF) m_dropped++;
      m_ovf = 1;
    end else begin
      mq.push_back({ts, d});
    end
  endtask

  task automatic m_pop(output logic [31:0] d);
    ent_t e;
    d = '0;
    if (mq.size() != 0) begin
      e = mq.pop_front();
      d = 32'(e.data);
      m_last_ts = e.ts;
    end
  endtask

  // Same-cycle push and pop: fullness and emptiness are judged before either takes effect.
  task automatic m_push_pop(input logic [DATA_W-1:0] d, input logic [31:0] ts,
                            output logic [31:0] o);
    bit was_empty;
    was_empty = (mq.size() == 0);
    m_push(d, ts);
    o = '0;
    if (!was_empty) m_pop(o);
  endtask

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    if (a == 32'h08) m_thresh = d[9:0];
    if (a == 32'h0C) begin
      m_en = d[0]; m_irqen = d[1];
      if (d[2]) begin mq.delete(); m_dropped = 0; m_ovf = 0; end
    end
  endtask

  // Bus tasks start and end at a negedge; push drives wr_en only in the handshake cycle.
  task automatic axi_read(input logic [31:0] addr, input bit push, input logic [DATA_W-1:0] pd,
                          output logic [31:0] data, output logic [1:0] resp,
                          output logic [31:0] push_ts);
    int n = 0;
    axi.araddr = addr; axi.arvalid = 1'b1;
    while (axi.arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin errors++; $display("FAIL ar_timeout: arready got %b required 1", axi.arready); end
    checks++;
    wr_en = push; data_in = pd; push_ts = cyc;
    @(posedge clk);
    @(negedge clk);
    axi.arvalid = 1'b0; wr_en = 1'b0;
    n = 0;
    while (axi.rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin errors++; $display("FAIL r_timeout: rvalid got %b required 1", axi.rvalid); end
    checks++;
    data = axi.rdata; resp = axi.rresp; axi.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi.rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input bit push,
                           input logic [DATA_W-1:0] pd, output logic [1:0] resp);
    int n = 0;
    axi.awaddr = addr; axi.wdata = data; axi.wstrb = 4'hF; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    while (axi.awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin errors++; $display("FAIL aw_timeout: awready got %b required 1", axi.awready); end
    checks++;
    wr_en = push; data_in = pd;
    @(posedge clk);
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; wr_en = 1'b0;
    n = 0;
    while (axi.bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin errors++; $display("FAIL b_timeout: bvalid got %b required 1", axi.bvalid); end
    checks++;
    resp = axi.bresp; axi.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi.bready = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] addr, output logic [31:0] data);
    logic [1:0]  r;
    logic [31:0] t;
    axi_read(addr, 1'b0, '0, data, r, t);
  endtask

  task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
    logic [1:0] r;
    axi_write(addr, data, 1'b0, '0, r);
    m_write(addr, data);
  endtask

  task automatic push_n(input int n, input bit rnd, input logic [DATA_W-1:0] d);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      data_in = rnd ? DATA_W'($urandom) : d;
      m_push(data_in, cyc);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    axi.arvalid = 0; axi.rready = 0; axi.awvalid = 0; axi.wvalid = 0; axi.bready = 0;
    axi.araddr = '0; axi.awaddr = '0; axi.wdata = '0; axi.wstrb = '0; wr_en = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_regs_at_reset(input string tag);
    logic [31:0] v;
    rd_reg(32'h00, v);
    if (v !== 32'h1) begin errors++; $display("FAIL %s_status: got %h required %h", tag, v, 32'h1); end
    checks++;
    rd_reg(32'h04, v);
    if (v !== 32'h0) begin errors++; $display("FAIL %s_level: got %h required 0", tag, v); end
    checks++;
    rd_reg(32'h08, v);
    if (v !== 32'd256) begin errors++; $display("FAIL %s_thresh: got %0d required 256", tag, v); end
    checks++;
    rd_reg(32'h0C, v);
    if (v !== 32'h1) begin errors++; $display("FAIL %s_ctrl: got %h required 1", tag, v); end
    checks++;
    rd_reg(32'h10, v);
    if (v !== 32'h0) begin errors++; $display("FAIL %s_dropped: got %h required 0", tag, v); end
    checks++;
    rd_reg(32'h18, v);
    if (v !== 32'h0) begin errors++; $display("FAIL %s_ts: got %h required 0", tag, v); end
    checks++;
  endtask

  task automatic test_reset();
    apply_reset();
    if ({axi.arready, axi.rvalid, axi.awready, axi.bvalid, irq} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000",
               {axi.arready, axi.rvalid, axi.awready, axi.bvalid, irq});
    end
    checks++;
    check_regs_at_reset("reset");
    axi_read(32'h14, 1'b0, '0, rd, rs, pts);
    if (rd !== 32'h0 || rs !== 2'b00) begin
      errors++; $display("FAIL reset_empty_pop: got %h/%b required 0/00", rd, rs);
    end
    checks++;
    rd_reg(32'h04, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_level_after_pop: got %h required 0", rd); end
    checks++;
  endtask

  task automatic test_basic();
    logic [31:0] prev_ts;
    for (int i = 1; i <= 4; i++) push_n(1, 1'b0, DATA_W'(i));
    rd_reg(32'h00, rd);
    if (rd !== m_status()) begin errors++; $display("FAIL basic_status: got %h required %h", rd, m_status()); end
    checks++;
    rd_reg(32'h04, rd);
    if (rd !== 32'(mq.size())) begin errors++; $display("FAIL basic_level: got %0d required %0d", rd, mq.size()); end
    checks++;
    for (int i = 0; i < 4; i++) begin
      m_pop(exp);
      rd_reg(32'h14, rd);
      if (rd !== exp) begin errors++; $display("FAIL basic_pop%0d: got %h required %h", i, rd, exp); end
      checks++;
      rd_reg(32'h18, rd);
      if (rd !== m_last_ts) begin errors++; $display("FAIL basic_ts%0d: got %h required %h", i, rd, m_last_ts); end
      checks++;
      if (i > 0 && rd - prev_ts !== 32'd1) begin
        errors++; $display("FAIL basic_ts_step%0d: got %0d required 1", i, rd - prev_ts);
      end
      if (i > 0) checks++;
      prev_ts = rd;
    end
    rd_reg(32'h00, rd);
    if (rd !== 32'h1) begin errors++; $display("FAIL basic_status_empty: got %h required 1", rd); end
    checks++;
  endtask

  task automatic test_overflow();
    push_n(DEPTH + 10, 1'b0, 9'h10F);
    if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq: got %b required 0", irq); end
    checks++;
    rd_reg(32'h00, rd);
    if (rd !== 32'hE || rd !== m_status()) begin
      errors++; $display("FAIL ovf_status: got %h required %h", rd, m_status());
    end
    checks++;
    rd_reg(32'h04, rd);
    if (rd !== 32'd512) begin errors++; $display("FAIL ovf_level: got %0d required 512", rd); end
    checks++;
    rd_reg(32'h10, rd);
    if (rd !== 32'd10) begin errors++; $display("FAIL ovf_dropped: got %0d required 10", rd); end
    checks++;
    // Pop while full with a same-cycle write: the write is still dropped.
    axi_read(32'h14, 1'b1, 9'h055, rd, rs, pts);
    m_push_pop(9'h055, pts, exp);
    if (rd !== 32'h10F || rd !== exp) begin errors++; $display("FAIL ovf_pop: got %h required %h", rd, exp); end
    checks++;
    rd_reg(32'h04, rd);
    if (rd !== 32'd511) begin errors++; $display("FAIL ovf_level_after_pop: got %0d required 511", rd); end
    checks++;
    rd_reg(32'h10, rd);
    if (rd !== 32'(m_dropped)) begin errors++; $display("FAIL ovf_dropped_pop: got %0d required %0d", rd, m_dropped); end
    checks++;
  endtask

  task automatic test_flush();
    push_n(1, 1'b0, 9'h1AA);
    rd_reg(32'h04, rd);
    if (rd !== 32'd512) begin errors++; $display("FAIL flush_refill: got %0d required 512", rd); end
    checks++;
    // Flush with a same-cycle write: that write is discarded and not counted.
    axi_write(32'h0C, 32'h7, 1'b1, 9'h033, rs);
    m_write(32'h0C, 32'h7);
    rd_reg(32'h04, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL flush_level: got %0d required 0", rd); end
    checks++;
    rd_reg(32'h10, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL flush_dropped: got %0d required 0", rd); end
    checks++;
    rd_reg(32'h00, rd);
    if (rd !== 32'h1) begin errors++; $display("FAIL flush_status: got %h required 1", rd); end
    checks++;
    rd_reg(32'h0C, rd);
    if (rd !== 32'h3) begin errors++; $display("FAIL flush_ctrl: got %h required 3", rd); end
    checks++;
    wr_reg(32'h0C, 32'h2);
    push_n(3, 1'b1, '0);
    rd_reg(32'h04, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL disabled_level: got %0d required 0", rd); end
    checks++;
    rd_reg(32'h10, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL disabled_dropped: got %0d required 0", rd); end
    checks++;
  endtask

  task automatic test_irq();
    int prev;
    wr_reg(32'h08, 32'd3);
    wr_reg(32'h0C, 32'h3);
    prev = mq.size();
    for (int i = 0; i < 5; i++) begin
      wr_en = (i < 3); data_in = DATA_W'(i + 7);
      if (i < 3) m_push(data_in, cyc);
      @(negedge clk);
      if (irq !== (m_irqen && prev >= int'(m_thresh))) begin
        errors++; $display("FAIL irq_rise%0d: got %b required %b", i, irq, prev >= int'(m_thresh));
      end
      checks++;
      prev = mq.size();
    end
    m_pop(exp);
    rd_reg(32'h14, rd);
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b required 0", irq); end
    checks++;
    wr_reg(32'h08, 32'd0);
    for (int i = 0; i < 2; i++) begin m_pop(exp); rd_reg(32'h14, rd); end
    @(negedge clk);
    if (irq !== 1'b1 || mq.size() != 0) begin errors++; $display("FAIL irq_thresh0: got %b required 1", irq); end
    checks++;
    wr_reg(32'h0C, 32'h1);
    wr_reg(32'h08, 32'd4);
  endtask

  task automatic test_back_to_back();
    logic [31:0] b_ts;
    push_n(1, 1'b0, 9'h0A1);
    axi_read(32'h14, 1'b1, 9'h0B2, rd, rs, pts);
    b_ts = pts;
    m_push_pop(9'h0B2, pts, exp);
    if (rd !== 32'h0A1 || rd !== exp) begin errors++; $display("FAIL b2b_old: got %h required %h", rd, exp); end
    checks++;
    rd_reg(32'h04, rd);
    if (rd !== 32'd1) begin errors++; $display("FAIL b2b_level: got %0d required 1", rd); end
    checks++;
    m_pop(exp);
    rd_reg(32'h14, rd);
    if (rd !== 32'h0B2) begin errors++; $display("FAIL b2b_new: got %h required 0b2", rd); end
    checks++;
    rd_reg(32'h18, rd);
    if (rd !== b_ts) begin errors++; $display("FAIL b2b_ts: got %h required %h", rd, b_ts); end
    checks++;
  endtask

  task automatic test_random();
    int op;
    wr_reg(32'h08, 32'($urandom_range(0, 8)));
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: push_n($urandom_range(1, 6), 1'b1, '0);
        1: begin
          m_pop(exp);
          rd_reg(32'h14, rd);
          if (rd !== exp) begin errors++; $display("FAIL rnd_pop%0d: got %h required %h", it, rd, exp); end
          checks++;
          rd_reg(32'h18, rd);
          if (rd !== m_last_ts) begin errors++; $display("FAIL rnd_ts%0d: got %h required %h", it, rd, m_last_ts); end
          checks++;
        end
        2: begin
          rd_reg(32'h04, rd);
          if (rd !== 32'(mq.size())) begin errors++; $display("FAIL rnd_level%0d: got %0d required %0d", it, rd, mq.size()); end
          checks++;
          rd_reg(32'h00, rd);
          if (rd !== m_status()) begin errors++; $display("FAIL rnd_status%0d: got %h required %h", it, rd, m_status()); end
          checks++;
        end
        default: begin
          logic [DATA_W-1:0] d;
          d = DATA_W'($urandom);
          axi_read(32'h14, 1'b1, d, rd, rs, pts);
          m_push_pop(d, pts, exp);
          if (rd !== exp) begin errors++; $display("FAIL rnd_pushpop%0d: got %h required %h", it, rd, exp); end
          checks++;
        end
      endcase
    end
  endtask

  task automatic test_errors();
    axi_read(32'h20, 1'b0, '0, rd, rs, pts);
    if (rd !== 32'h0 || rs !== 2'b10) begin errors++; $display("FAIL bad_read: got %h/%b required 0/10", rd, rs); end
    checks++;
    exp = 32'(mq.size());
    axi_write(32'h04, 32'h5, 1'b0, '0, rs);
    if (rs !== 2'b10) begin errors++; $display("FAIL ro_write_bresp: got %b required 10", rs); end
    checks++;
    rd_reg(32'h04, rd);
    if (rd !== exp) begin errors++; $display("FAIL ro_write_level: got %0d required %0d", rd, exp); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    push_n(2, 1'b1, '0);
    wr_reg(32'h08, 32'd0);
    wr_reg(32'h0C, 32'h3);
    @(negedge clk);
    axi.araddr = 32'h14; axi.arvalid = 1'b1;
    while (axi.rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    axi.arvalid = 1'b0;
    if (axi.rvalid !== 1'b1 || irq !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got rvalid %b irq %b required 1 1", axi.rvalid, irq);
    end
    checks++;
    rst_n = 1'b0;
    #1;
    if ({axi.rvalid, axi.arready, irq, axi.bvalid} !== 4'b0) begin
      errors++; $display("FAIL mid_async: got %b required 0000", {axi.rvalid, axi.arready, irq, axi.bvalid});
    end
    checks++;
    apply_reset();
    check_regs_at_reset("mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_flush();
    test_irq();
    test_back_to_back();
    test_random();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/event_fifo_ts.md
Name: event_fifo_ts

Overview:
- Parametrised event FIFO with per-entry timestamps and an AXI4-Lite slave for status, configuration and pop-on-read.
- Captures event codes from the event decoder on a single write strobe and timestamps each one from a free-running counter.
- Software drains events over AXI. The block provides overflow accounting, a programmable level threshold, a level interrupt and a soft flush.

Parameters:
- DATA_W, 9, event code width, 1..32.
- DEPTH, 512, FIFO entries; power of two, at least 4.
- TS_W, 32, timestamp counter width, 1..32.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- wr_en  in  1  event strobe; one entry per high cycle.
- data_in  in  DATA_W  event code, sampled when wr_en=1.
- irq  out  1  level interrupt, high when (LEVEL >= THRESH) and CTRL.irq_en.
- axi  axi4_lite_if slave modport  32-bit address and data.

Behaviour:
- Reset state (asynchronous, via aresetn):
  - FIFO empty, LEVEL=0, DROPPED=0, overflow=0, timestamp counter=0.
  - THRESH=DEPTH/2, CTRL.enable=1, CTRL.irq_en=0, last_ts=0.
  - irq=0, arready=0, rvalid=0, awready=0, wready=0, bvalid=0, rdata=0, rresp=0, bresp=0.
- Timestamp counter increments by 1 every cycle and wraps modulo 2^TS_W.
- Write side:
  - Storage is {ts, data_in}, with ts = counter value in the strobe cycle.
  - The entry is stored only if wr_en=1, enable=1 and FIFO not full; it is visible (LEVEL updated, empty deasserted) the next cycle.
  - wr_en=1 while full: entry dropped, DROPPED+=1 (saturates at 2^32-1), overflow sticky set.
  - Full is evaluated before any same-cycle pop: a write while full is dropped even if a pop occurs in the same cycle.
  - wr_en=1 with enable=0: ignored, not counted.
- Register map (32-bit, word aligned; unused bits read 0):
  - 0x00 STATUS RO: bit0 empty, bit1 full, bit2 level>=THRESH, bit3 overflow sticky.
  - 0x04 LEVEL RO: entry count, 0..DEPTH.
  - 0x08 THRESH RW: bits [log2(DEPTH):0].
  - 0x0C CTRL RW: bit0 enable, bit1 irq_en, bit2 flush (write 1; reads 0).
  - 0x10 DROPPED RO.
  - 0x14 DATA RO, pop: returns entry data in [DATA_W-1:0] and latches its ts into last_ts. When empty it returns 0, does not pop, and leaves last_ts unchanged.
  - 0x18 TS RO: last_ts.
  - Other addresses: read data 0, RRESP/BRESP=SLVERR (2'b10), no side effects.
- AXI read:
  - One outstanding transaction.
  - arready=1 while no read response is pending.
  - The pop happens at the AR handshake cycle.
  - rvalid asserts the cycle after the handshake with rdata/rresp valid, and holds until rready.
  - arready=0 from the handshake until the R handshake completes.
- AXI write:
  - awready=wready=1 for one cycle when awvalid and wvalid are both high and no B response is pending.
  - Register update happens at that cycle.
  - bvalid the next cycle, held until bready. wstrb is ignored.
- Flush (CTRL.flush=1):
  - Next cycle: FIFO empty, LEVEL=0, DROPPED=0, overflow=0.
  - A wr_en in the flush cycle is discarded and not counted.
  - THRESH, CTRL and the timestamp counter are unaffected.
- Simultaneous push and pop when not full: LEVEL unchanged, both take effect.
- Pop of the last entry together with a push: the popped data is the old entry; the new entry remains.
- irq is registered (one cycle after the LEVEL/THRESH/irq_en change).
- THRESH=0 with irq_en=1: irq stays high.
- Reset mid-transaction aborts any AXI transfer; all state returns to reset values.

Test Plan:
1. After reset: read 0x00 -> 0x1; read 0x08 -> 256; read 0x14 -> 0 with RRESP=0 and LEVEL still 0.
2. Write codes 1,2,3,4 on consecutive cycles -> STATUS 0x0, LEVEL 4. Four reads of 0x14 -> 1,2,3,4. Each subsequent read of 0x18 differs from the previous one by exactly 1. Then STATUS 0x1.
3. Hold wr_en=1 with data 0x10F for DEPTH+10 cycles -> STATUS 0xE, LEVEL 512, DROPPED 10, irq stays 0 (irq_en=0). Read 0x14 -> 0x10F, LEVEL 511.
4. Write THRESH=3, CTRL=0x3, push 3 events -> irq rises one cycle after LEVEL reaches 3. One pop -> irq falls one cycle later.
5. At full, write CTRL=0x7 -> LEVEL 0, DROPPED 0, STATUS 0x1, CTRL reads 0x3. With CTRL=0x2 (disabled), pulse wr_en -> LEVEL stays 0, DROPPED stays 0.
6. Read 0x20 -> data 0, RRESP=2. Write 0x04 -> BRESP=2, LEVEL unchanged. Assert aresetn=0 while rvalid=1 -> rvalid=0 immediately and all registers at reset values.
